// File: rtl/data_sync_pkg.sv
// rtl/data_sync_pkg.sv - shared defaults and pointer helper for the data_sync receive path
package data_sync_pkg;

  localparam int DS_DATA_WIDTH     = 8;
  localparam int DS_DEPTH          = 8;
  localparam int DS_DROP_CNT_WIDTH = 8;

  // Advance a ring-buffer pointer, wrapping depth-1 back to 0.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 == depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/data_sync_fifo_mem.sv
// rtl/data_sync_fifo_mem.sv - register-array storage with synchronous write and asynchronous read
module data_sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is left unreset; occupancy tracking in the parent decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/data_sync_rx_fifo.sv
// rtl/data_sync_rx_fifo.sv - first-word-fall-through receive buffer with drop accounting
module data_sync_rx_fifo
  import data_sync_pkg::*;
#(
  parameter  int DATA_WIDTH     = DS_DATA_WIDTH,
  parameter  int DEPTH          = DS_DEPTH,
  parameter  int DROP_CNT_WIDTH = DS_DROP_CNT_WIDTH,
  localparam int ADDR_WIDTH     = $clog2(DEPTH)
) (
  input  logic                      dest_clk,
  input  logic                      dest_rst_n,
  input  logic [DATA_WIDTH-1:0]     sync_bus,
  input  logic                      enable_pulse,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      fifo_full,
  output logic [ADDR_WIDTH:0]       fifo_count,
  output logic                      overflow,
  input  logic                      overflow_clr,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam logic [ADDR_WIDTH:0]       FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX   = '1;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] head_word;
  logic                  rd;
  logic                  wr;
  logic                  drop;

  // A read frees a slot in the same cycle, so a full buffer still accepts a word when it is also being read.
  assign out_valid = (count != '0);
  assign rd        = out_valid && out_ready;
  assign wr        = enable_pulse && ((count < FULL_COUNT) || rd);
  assign drop      = enable_pulse && (count == FULL_COUNT) && !rd;

  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_count = count;
  assign out_data   = out_valid ? head_word : '0;

  data_sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (dest_clk),
    .wr_en   (wr),
    .wr_addr (wr_ptr),
    .wr_data (sync_bus),
    .rd_addr (rd_ptr),
    .rd_data (head_word)
  );

  // Pointer and occupancy bookkeeping; simultaneous read and write leave count unchanged.
  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= ADDR_WIDTH'(ptr_next(32'(wr_ptr), DEPTH));
      end
      if (rd) begin
        rd_ptr <= ADDR_WIDTH'(ptr_next(32'(rd_ptr), DEPTH));
      end
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a drop in the clearing cycle restarts the tally at one.
  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (overflow_clr) begin
        drop_count <= DROP_CNT_WIDTH'(1);
      end else if (drop_count != DROP_MAX) begin
        drop_count <= drop_count + 1'b1;
      end
    end else if (overflow_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_data_sync_rx_fifo.sv
// tb/tb_data_sync_rx_fifo.sv - scoreboard bench for data_sync_rx_fifo
module tb_data_sync_rx_fifo;

  localparam int DEPTH = 8;

  logic       dest_clk;
  logic       dest_rst_n;
  logic [7:0] sync_bus;
  logic       enable_pulse;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       fifo_full;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       overflow_clr;
  logic [7:0] drop_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       m_ovf  = 1'b0;
  logic [7:0] m_drop = 8'd0;

  data_sync_rx_fifo dut (
    .dest_clk     (dest_clk),
    .dest_rst_n   (dest_rst_n),
    .sync_bus     (sync_bus),
    .enable_pulse (enable_pulse),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .drop_count   (drop_count)
  );

  initial begin
    dest_clk = 1'b0;
    forever #5 dest_clk = ~dest_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(fifo_count), 32'(exp_q.size()));
    chk({tag, ".valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    chk({tag, ".data"}, 32'(out_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    chk({tag, ".full"}, 32'(fifo_full), 32'(exp_q.size() == DEPTH));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".drops"}, 32'(drop_count), 32'(m_drop));
  endtask

  // Called at posedge+1; drives one cycle, updates the model, then checks after the edge.
  task automatic step(input string tag, input logic en, input logic [7:0] d,
                      input logic rdy, input logic clr);
    bit         rd;
    bit         wr;
    bit         dp;
    logic [7:0] head;
    enable_pulse = en;
    sync_bus     = d;
    out_ready    = rdy;
    overflow_clr = clr;
    rd = (exp_q.size() != 0) && rdy;
    wr = en && ((exp_q.size() < DEPTH) || rd);
    dp = en && (exp_q.size() == DEPTH) && !rd;
    if (rd) begin
      head = exp_q.pop_front();
      chk({tag, ".rd_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".rd_data"}, 32'(out_data), 32'(head));
    end
    if (wr) exp_q.push_back(d);
    if (dp) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 8'd1 : ((m_drop == 8'hff) ? 8'hff : m_drop + 8'd1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 8'd0;
    end
    @(posedge dest_clk);
    #1;
    enable_pulse = 1'b0;
    out_ready    = 1'b0;
    overflow_clr = 1'b0;
    check_state(tag);
  endtask

  initial begin
    dest_rst_n   = 1'b0;
    sync_bus     = 8'd0;
    enable_pulse = 1'b0;
    out_ready    = 1'b0;
    overflow_clr = 1'b0;
    repeat (2) @(posedge dest_clk);
    #1;
    check_state("reset");
    @(negedge dest_clk);
    dest_rst_n = 1'b1;
    @(posedge dest_clk);
    #1;

    // single word fall-through and consume
    step("w5", 1'b1, 8'd5, 1'b0, 1'b0);
    step("r5", 1'b0, 8'd0, 1'b1, 1'b0);
    step("empty_ready", 1'b0, 8'd0, 1'b1, 1'b0);
    step("empty_wr_rd", 1'b1, 8'd11, 1'b1, 1'b0);
    step("r11", 1'b0, 8'd0, 1'b1, 1'b0);

    // burst of three then in-order drain
    step("w15", 1'b1, 8'd15, 1'b0, 1'b0);
    step("w20", 1'b1, 8'd20, 1'b0, 1'b0);
    step("w25", 1'b1, 8'd25, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("drain3", 1'b0, 8'd0, 1'b1, 1'b0);

    // fill, drop, full+write+read, drain
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    step("drop9", 1'b1, 8'd9, 1'b0, 1'b0);
    step("full_wr_rd", 1'b1, 8'd99, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain8", 1'b0, 8'd0, 1'b1, 1'b0);

    // overflow_clr alone, then together with a drop
    step("clr", 1'b0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, 8'(40 + i), 1'b0, 1'b0);
    step("clr_drop", 1'b1, 8'd77, 1'b0, 1'b1);

    // saturation of the drop counter
    for (int i = 0; i < 260; i++) step("sat", 1'b1, 8'(i), 1'b0, 1'b0);
    chk("sat_final", 32'(drop_count), 32'hff);

    // asynchronous reset mid-cycle with data buffered and overflow set
    #3;
    dest_rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_ovf  = 1'b0;
    m_drop = 8'd0;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.count", 32'(fifo_count), 32'd0);
    chk("rst.ovf", 32'(overflow), 32'd0);
    chk("rst.drops", 32'(drop_count), 32'd0);
    @(posedge dest_clk);
    @(negedge dest_clk);
    dest_rst_n = 1'b1;
    @(posedge dest_clk);
    #1;
    check_state("post_rst");
    step("w7", 1'b1, 8'd7, 1'b0, 1'b0);
    step("r7", 1'b0, 8'd0, 1'b1, 1'b0);

    // pointer wrap with interleaved traffic
    for (int i = 0; i < 20; i++) step("wrap", 1'b1, 8'(100 + i), (i % 3) != 0, 1'b0);
    for (int i = 0; i < 2 * DEPTH && exp_q.size() != 0; i++) step("wrap_drain", 1'b0, 8'd0, 1'b1, 1'b0);
    chk("wrap_empty", 32'(fifo_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_sync_rx_fifo.md
Name: data_sync_rx_fifo

Overview:
- Destination-domain receive buffer directly downstream of data_sync_top_module.
- Captures every word presented on sync_bus while enable_pulse is high and stores it in a small first-word-fall-through FIFO.
- Presents the words to the consumer over a valid/ready handshake.
- Flags and counts words lost because the buffer was full, so slow consumers never silently corrupt the stream.

Parameters:
- DATA_WIDTH, 8: width of sync_bus and out_data.
- DEPTH, 8: number of FIFO entries; must be a power of two, at least 2.
- ADDR_WIDTH, $clog2(DEPTH): pointer width (derived localparam, not overridable).
- DROP_CNT_WIDTH, 8: width of the saturating dropped-word counter.

Ports:
- dest_clk  in  1  destination clock; all logic on rising edge.
- dest_rst_n  in  1  asynchronous, active-low reset.
- sync_bus  in  DATA_WIDTH  synchronized data from data_sync_top_module.
- enable_pulse  in  1  single-cycle strobe marking sync_bus valid.
- out_data  out  DATA_WIDTH  head-of-FIFO word.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts out_data this cycle.
- fifo_full  out  1  count == DEPTH.
- fifo_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a word was dropped.
- overflow_clr  in  1  clears overflow and drop_count.
- drop_count  out  DROP_CNT_WIDTH  saturating count of dropped words.

Behaviour:
- Clocking and reset: one clock, dest_clk. Reset is asynchronous, active-low on dest_rst_n.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_data=0, fifo_full=0, fifo_count=0, overflow=0, drop_count=0. Memory contents are not reset.
- Write event (wr): enable_pulse==1 and (count<DEPTH, or read event in the same cycle).
  - Stores sync_bus at mem[wr_ptr].
  - wr_ptr increments modulo DEPTH, wrapping DEPTH-1 -> 0.
- Read event (rd): out_valid==1 and out_ready==1.
  - rd_ptr increments modulo DEPTH.
- Count update per edge:
  - +1 on wr only.
  - -1 on rd only.
  - Unchanged on both or neither.
- Output path is first-word-fall-through:
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] when out_valid, else 0.
  - Latency: a word written at edge N appears on out_data/out_valid immediately after edge N. It can be consumed at edge N+1.
- Drop: enable_pulse==1, count==DEPTH and no read event that cycle.
  - Word discarded; pointers and count unchanged.
  - overflow set to 1.
  - drop_count increments, saturating at all-ones.
- Boundary: full plus write plus read in the same cycle: both occur, count stays DEPTH, no drop.
- Boundary: empty plus write plus out_ready=1: no read (out_valid is 0), write occurs, count becomes 1.
- Boundary: out_ready=1 while empty is ignored; no pointer movement, no underflow.
- overflow_clr:
  - Clears overflow and drop_count at the next edge.
  - A drop in the same cycle wins: overflow=1, drop_count=1.
- fifo_full and fifo_count are combinational from the count register.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Buffered words are lost. The first enable_pulse after deassertion is stored at mem[0].
- enable_pulse held high for several cycles is treated as one write per cycle; no edge detection in this block.

Decomposition:
- Shared package data_sync_pkg:
  - default DATA_WIDTH, DEPTH, DROP_CNT_WIDTH constants.
  - A function for pointer increment with wrap.
- One sub-module, data_sync_fifo_mem:
  - DEPTH x DATA_WIDTH register array.
  - Synchronous write port and asynchronous read port.
- Pointer, count, flag and drop logic stay in data_sync_rx_fifo.

Test Plan:
- Reset, then enable_pulse with sync_bus=8'd5, out_ready=0 -> out_valid=1, out_data=5, fifo_count=1 after that edge. With out_ready=1 the next edge gives fifo_count=0, out_valid=0, out_data=0.
- Write 8'd15, 8'd20, 8'd25 on consecutive cycles with out_ready=0 -> fifo_count=3. Then raise out_ready -> reads 15, 20, 25 in order, one per cycle, then out_valid=0.
- Write 8 words 1..8 with out_ready=0 -> fifo_full=1, fifo_count=8. Then write 9 -> overflow=1, drop_count=1, head still 1. Then drain -> reads 1..8, no 9.
- Full FIFO, enable_pulse with sync_bus=8'd99 and out_ready=1 in the same cycle -> no drop, fifo_count stays 8, 99 becomes the last entry read.
- Pulse overflow_clr with no drop -> overflow=0, drop_count=0. Pulse overflow_clr together with a drop -> overflow=1, drop_count=1.
- Write 3 words, assert dest_rst_n=0 mid-cycle -> out_valid, fifo_count, overflow go to 0 immediately. After release, write 8'd7 -> out_data=7, fifo_count=1. Also wrap pointers past DEPTH with 20 interleaved writes and reads, checking data order.
